// File: rtl/mips_multicycle_ctrl_if.sv
// Memory access port of the multicycle controller: strobes and address select
// toward instruction/data memory, ready back from it.
interface mips_multicycle_ctrl_if;
  // Handshake: a strobe (mem_read or mem_write) is a request that stays asserted,
  // with i_or_d stable, until the cycle in which the memory drives mem_ready=1;
  // that cycle completes the access. mem_ready has no meaning without a strobe.
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and decodes datapath selects from the registered state.
module mips_multicycle_ctrl #(
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mips_multicycle_ctrl_if.master        mem,
  input  logic [5:0]                    opcode,
  input  logic [5:0]                    funct,
  input  logic                          zero,
  output logic                          ir_write,
  output logic                          pc_en,
  output logic [1:0]                    pc_source,
  output logic                          pc_clr,
  output logic                          alu_src_a,
  output logic [1:0]                    alu_src_b,
  output logic [3:0]                    alu_ctl,
  output logic                          ext_sign,
  output logic                          reg_dst,
  output logic                          mem_to_reg,
  output logic                          reg_write,
  output logic                          illegal,
  output logic [3:0]                    state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REX    = 4'd7,
    S_RWB    = 4'd8,
    S_BR     = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11,
    S_JMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t cur, nxt;
  logic [3:0] r_alu;
  logic       r_ok;
  logic [3:0] i_alu;
  logic       i_sign;

  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // R-type funct decode; r_ok=0 flags an unsupported funct.
  always_comb begin
    r_alu = ALU_AND;
    r_ok  = 1'b1;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_ok  = 1'b0;
    endcase
  end

  // Immediate-ALU decode, shared by IEX and IWB so both see the same values.
  always_comb begin
    i_alu  = ALU_ADD;
    i_sign = 1'b1;
    case (opcode)
      OP_SLTI: i_alu = ALU_SLT;
      OP_ANDI: begin i_alu = ALU_AND; i_sign = 1'b0; end
      OP_ORI:  begin i_alu = ALU_OR;  i_sign = 1'b0; end
      default: begin i_alu = ALU_ADD; i_sign = 1'b1; end
    endcase
  end

  always_comb begin
    nxt           = cur;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.i_or_d    = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_source     = 2'b00;
    pc_clr        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctl       = 4'b0000;
    ext_sign      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    case (cur)
      S_IDLE: begin
        pc_clr = RESET_PC_ZERO;
        nxt    = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_read = 1'b1;
        alu_src_b    = 2'b01;
        alu_ctl      = ALU_ADD;
        ir_write     = mem.mem_ready;
        pc_en        = mem.mem_ready;
        if (mem.mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_sign  = 1'b1;
        alu_ctl   = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:                      nxt = S_MEMADR;
          OP_RTYPE:                          nxt = S_REX;
          OP_BEQ, OP_BNE:                    nxt = S_BR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = S_IEX;
          OP_J:                              nxt = S_JMP;
          default: begin
            illegal = 1'b1;
            nxt     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_sign  = 1'b1;
        alu_ctl   = ALU_ADD;
        nxt       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem.mem_read = 1'b1;
        mem.i_or_d   = 1'b1;
        if (mem.mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        mem.mem_write = 1'b1;
        mem.i_or_d    = 1'b1;
        if (mem.mem_ready) nxt = S_FETCH;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_ctl   = r_alu;
        illegal   = !r_ok;
        nxt       = r_ok ? S_RWB : S_FETCH;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nxt       = S_FETCH;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_source = 2'b01;
        pc_en     = (opcode == OP_BNE) ? !zero : zero;
        nxt       = S_FETCH;
      end
      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctl   = i_alu;
        ext_sign  = i_sign;
        nxt       = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        alu_ctl   = i_alu;
        ext_sign  = i_sign;
        nxt       = S_FETCH;
      end
      S_JMP: begin
        pc_en     = 1'b1;
        pc_source = 2'b10;
        nxt       = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected output vectors are queued
// as stimulus is driven and compared on the falling edge.
module tb_mips_multicycle_ctrl;

  // Observed/expected vector layout:
  // [23:20] state, 19 illegal, 18 mem_read, 17 mem_write, 16 i_or_d, 15 ir_write,
  // 14 pc_en, [13:12] pc_source, 11 pc_clr, 10 alu_src_a, [9:8] alu_src_b,
  // [7:4] alu_ctl, 3 ext_sign, 2 reg_dst, 1 mem_to_reg, 0 reg_write
  localparam logic [23:0] ILL     = 24'h080000;
  localparam logic [23:0] MR      = 24'h040000;
  localparam logic [23:0] MW      = 24'h020000;
  localparam logic [23:0] IOD     = 24'h010000;
  localparam logic [23:0] IRW     = 24'h008000;
  localparam logic [23:0] PCE     = 24'h004000;
  localparam logic [23:0] PS_J    = 24'h002000;
  localparam logic [23:0] PS_BR   = 24'h001000;
  localparam logic [23:0] PCLR    = 24'h000800;
  localparam logic [23:0] SA      = 24'h000400;
  localparam logic [23:0] SB_IMM4 = 24'h000300;
  localparam logic [23:0] SB_IMM  = 24'h000200;
  localparam logic [23:0] SB_4    = 24'h000100;
  localparam logic [23:0] A_SLT   = 24'h000070;
  localparam logic [23:0] A_SUB   = 24'h000060;
  localparam logic [23:0] A_ADD   = 24'h000020;
  localparam logic [23:0] A_OR    = 24'h000010;
  localparam logic [23:0] A_AND   = 24'h000000;
  localparam logic [23:0] EXT     = 24'h000008;
  localparam logic [23:0] RDST    = 24'h000004;
  localparam logic [23:0] M2R     = 24'h000002;
  localparam logic [23:0] RW      = 24'h000001;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       ir_write, pc_en, pc_clr, alu_src_a, ext_sign, reg_dst, mem_to_reg, reg_write, illegal;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_ctl, state;
  logic [23:0] obs;

  logic [23:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  mips_multicycle_ctrl_if mem_if ();

  mips_multicycle_ctrl #(.RESET_PC_ZERO(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (mem_if.master),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_source  (pc_source),
    .pc_clr     (pc_clr),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctl    (alu_ctl),
    .ext_sign   (ext_sign),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .state      (state)
  );

  assign obs = {state, illegal, mem_if.mem_read, mem_if.mem_write, mem_if.i_or_d,
                ir_write, pc_en, pc_source, pc_clr, alu_src_a, alu_src_b, alu_ctl,
                ext_sign, reg_dst, mem_to_reg, reg_write};

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] st(input logic [3:0] n);
    return {n, 20'h00000};
  endfunction

  function automatic logic dc();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
  endtask

  // scoreboard: compare one queued expectation per falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) check(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  // driver tasks: called just after a rising edge, cover one clock cycle
  task automatic cyc(input logic [23:0] e, input logic rdy, input string tag);
    mem_if.mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int nwait, input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = 0; i < nwait; i++) cyc(st(1) | MR | SB_4 | A_ADD, 1'b0, "fetch_wait");
    cyc(st(1) | MR | SB_4 | A_ADD | IRW | PCE, 1'b1, "fetch");
  endtask

  task automatic decode(input logic ill);
    cyc(st(2) | SB_IMM4 | EXT | A_ADD | (ill ? ILL : 24'h0), dc(), ill ? "decode_illegal" : "decode");
  endtask

  logic [5:0]  r_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [23:0] r_al [5] = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT};
  logic [5:0]  i_op [4] = '{6'b001000, 6'b001010, 6'b001100, 6'b001101};
  logic [23:0] i_al [4] = '{A_ADD | EXT, A_SLT | EXT, A_AND, A_OR};

  initial begin
    rst_n = 1'b0;
    opcode = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    mem_if.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(st(0) | PCLR, 1'b1, "reset_idle");
    rst_n = 1'b1;
    cyc(st(0) | PCLR, 1'b1, "post_reset_idle");

    // lw with two wait cycles in MEMRD: 1,2,3,4,4,4,5
    fetch(0, 6'b100011, 6'd0, 1'b0);
    decode(1'b0);
    cyc(st(3) | SA | SB_IMM | EXT | A_ADD, dc(), "lw_memadr");
    cyc(st(4) | MR | IOD, 1'b0, "lw_memrd_wait");
    cyc(st(4) | MR | IOD, 1'b0, "lw_memrd_wait");
    cyc(st(4) | MR | IOD, 1'b1, "lw_memrd");
    cyc(st(5) | RW | M2R, dc(), "lw_memwb");

    // sw with random waits in FETCH and MEMWR
    begin
      int fw, ww;
      fw = $urandom_range(0, 3);
      ww = $urandom_range(0, 3);
      fetch(fw, 6'b101011, 6'd0, 1'b0);
      decode(1'b0);
      cyc(st(3) | SA | SB_IMM | EXT | A_ADD, dc(), "sw_memadr");
      for (int i = 0; i < ww; i++) cyc(st(6) | MW | IOD, 1'b0, "sw_memwr_wait");
      cyc(st(6) | MW | IOD, 1'b1, "sw_memwr");
    end

    for (int k = 0; k < 5; k++) begin
      fetch(0, 6'b000000, r_fn[k], dc());
      decode(1'b0);
      cyc(st(7) | SA | r_al[k], dc(), "rex");
      cyc(st(8) | RW | RDST, dc(), "rwb");
    end

    fetch(0, 6'b000000, 6'b000111, 1'b0);
    decode(1'b0);
    cyc(st(7) | SA | ILL, dc(), "rex_illegal");

    fetch(0, 6'b000100, 6'd0, 1'b1);
    decode(1'b0);
    cyc(st(9) | SA | A_SUB | PS_BR | PCE, dc(), "beq_taken");
    fetch(0, 6'b000100, 6'd0, 1'b0);
    decode(1'b0);
    cyc(st(9) | SA | A_SUB | PS_BR, dc(), "beq_not_taken");
    fetch(0, 6'b000101, 6'd0, 1'b0);
    decode(1'b0);
    cyc(st(9) | SA | A_SUB | PS_BR | PCE, dc(), "bne_taken");
    fetch(0, 6'b000101, 6'd0, 1'b1);
    decode(1'b0);
    cyc(st(9) | SA | A_SUB | PS_BR, dc(), "bne_not_taken");

    for (int k = 0; k < 4; k++) begin
      fetch(0, i_op[k], 6'($urandom_range(0, 63)), dc());
      decode(1'b0);
      cyc(st(10) | SA | SB_IMM | i_al[k], dc(), "iex");
      cyc(st(11) | RW | i_al[k], dc(), "iwb");
    end

    fetch(0, 6'b000010, 6'd0, 1'b0);
    decode(1'b0);
    cyc(st(12) | PCE | PS_J, dc(), "jmp");

    fetch(0, 6'b111111, 6'd0, 1'b0);
    decode(1'b1);

    // asynchronous reset in the middle of a MEMRD wait
    fetch(0, 6'b100011, 6'd0, 1'b0);
    decode(1'b0);
    cyc(st(3) | SA | SB_IMM | EXT | A_ADD, dc(), "lw2_memadr");
    mem_if.mem_ready = 1'b0;
    exp_q.push_back(st(4) | MR | IOD);
    tag_q.push_back("lw2_memrd_wait");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs, st(0) | PCLR);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(st(0) | PCLR, 1'b1, "rerun_idle");
    fetch(1, 6'b000010, 6'd0, 1'b0);
    decode(1'b0);
    cyc(st(12) | PCE | PS_J, dc(), "jmp2");

    @(negedge clk);
    #1;
    check("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back states. Each cycle it drives the datapath selects: PC, IR, register file, ALU, the memory strobes, and the extend-mode select of the sign-extension unit. It sits between the instruction register opcode/funct fields and the datapath muxes, and waits on a ready handshake from instruction/data memory.

## Interface
- RESET_PC_ZERO, 1, when 1 the controller also pulses pc_clr in IDLE (datapath clears PC); when 0 pc_clr stays 0
- clk  in  1  rising-edge clock
- rst_n  in  1  reset is asynchronous and active-low
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes current access this cycle
- mem_read / mem_write  out  1  memory strobes, held until mem_ready
- i_or_d  out  1  0 = address from PC, 1 = from ALUOut
- ir_write  out  1  load IR
- pc_en  out  1  PC load enable (branch condition already resolved)
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- pc_clr  out  1  PC clear
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 extended imm, 11 extended imm<<2
- alu_ctl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- ext_sign  out  1  1 = sign-extend imm16 to 32 bits, 0 = zero-extend
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data: 0 ALUOut, 1 MDR
- reg_write  out  1  register-file write enable
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct
- state  out  4  current state code, for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, RWB=8, BR=9, IEX=10, IWB=11, JMP=12.
- Outputs are decoded from the registered state. The exceptions, which also depend on inputs, are pc_en in FETCH/BR and ir_write.
- All outputs are 0 unless listed for a state.
- IDLE: pc_clr=RESET_PC_ZERO. Always goes to FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctl=add, pc_source=00.
  - ir_write and pc_en equal mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ext_sign=1, alu_ctl=add (branch target into ALUOut). Next state by opcode:
  - 100011/101011 → MEMADR
  - 000000 → REX
  - 000100/000101 → BR
  - 001000/001010/001100/001101 → IEX
  - 000010 → JMP
  - anything else → FETCH with illegal=1
- MEMADR: alu_src_a=1, alu_src_b=10, ext_sign=1, alu_ctl=add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next is FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- REX: alu_src_a=1, alu_src_b=00. alu_ctl from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct: illegal=1, next is FETCH with no write-back. Otherwise next is RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BR: alu_src_a=1, alu_src_b=00, alu_ctl=sub, pc_source=01.
  - pc_en = zero for beq, !zero for bne.
  - Next is FETCH.
- IEX: alu_src_a=1, alu_src_b=10.
  - addi: add, ext_sign=1. slti: slt, ext_sign=1. andi: and, ext_sign=0. ori: or, ext_sign=0.
  - Next is IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. ext_sign and alu_ctl are held at the IEX values. Next is FETCH.
- JMP: pc_en=1, pc_source=10. Next is FETCH.
- opcode/funct are sampled combinationally; the datapath holds IR stable outside FETCH.
- mem_read and mem_write are never both 1.

## Timing
- Reset value: state=IDLE, and every output 0. pc_clr is the exception and equals RESET_PC_ZERO.
- Assertion of rst_n low forces IDLE immediately, mid-instruction included. Any memory strobe drops the same instant.
- Latency with zero-wait memory (mem_ready always 1), counted from FETCH entry to next FETCH entry:
  - lw 5 cycles
  - sw 4
  - R-type 4
  - I-type ALU 4
  - beq/bne 3
  - j 3
  - illegal 2
- Each cycle that mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes, address select and state are held constant while waiting.
- mem_ready is ignored in every other state.
- After reset: one IDLE cycle, then FETCH.

## Test plan
- Reset, release with mem_ready=1 → IDLE 1 cycle then FETCH with mem_read=1, ir_write=1, pc_en=1, alu_src_b=01. Assert rst_n=0 during MEMRD → state=0 and mem_read=0 without a clock edge.
- lw (opcode 100011), mem_ready low 2 cycles in MEMRD → state sequence 1,2,3,4,4,4,5,1; MEMWB has reg_write=1, mem_to_reg=1, reg_dst=0; 7 cycles total.
- R-type funct 100010 → REX drives alu_ctl=0110; RWB has reg_write=1, reg_dst=1. Funct 000111 → illegal pulse for 1 cycle, no reg_write, back to FETCH.
- beq with zero=1 → pc_en=1, pc_source=01 in BR; beq with zero=0 → pc_en=0; bne with zero=0 → pc_en=1.
- andi 001100 and ori 001101 → ext_sign=0 in IEX and IWB. addi 001000 and slti 001010 → ext_sign=1, with alu_ctl 0010 and 0111 respectively.
- j 000010 → JMP with pc_en=1, pc_source=10. Opcode 111111 → illegal in DECODE, FETCH next, no other strobes asserted.
